// File: rtl/uart_stream_capture.sv
// 8N1 UART capture receiver with a valid/ready byte FIFO, line-end and end-of-test flags.
// Optional console echo and auto-finish when UART_STREAM_CAPTURE_DISPLAY_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit, rejects glitches
// S_DATA  | sampling 8 data bits LSB first, one per bit time
// S_STOP  | sampling stop bit; good stop completes the byte
// S_BREAK | stop bit was low, waiting for the line to return high
module uart_stream_capture #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  EOT_CHAR     = 8'h04,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RXD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [7:0]  OUT_DATA,
  output logic        LINE_END,
  output logic        FRAME_ERR,
  output logic        OVERFLOW,
  output logic        SIMULATIONEND,
  output logic [15:0] BYTE_COUNT
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  // The edge-detect cycle already counts toward the half bit, hence HALF-2.
  localparam logic [TW-1:0] START_LOAD = TW'(HALF - 2);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done_q, byte_done_d;
  logic            line_end_q, line_end_d;
  logic            frame_err_q, frame_err_d;
  logic            sim_end_q, sim_end_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     byte_count_q, byte_count_d;
  logic [7:0]      last_q, last_d;
  logic            full, push, pop, drop, tc;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    line_end_d  = 1'b0;
    frame_err_d = 1'b0;
    sim_end_d   = sim_end_q;
    tc          = (timer_q == '0);
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = S_START;
          timer_d   = START_LOAD;
          bit_cnt_d = 3'd0;
        end
      end
      S_START: begin
        if (tc) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            timer_d = BIT_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (tc) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          timer_d = BIT_LOAD;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_STOP: begin
        if (tc) begin
          if (rx_s_q) begin
            byte_done_d = 1'b1;
            line_end_d  = (shift_q == EOL_CHAR);
            if (shift_q == EOT_CHAR) sim_end_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shift_q stays stable through the completion cycle, so it is the push data.
  always_comb begin
    full         = (count_q == (AW+1)'(FIFO_DEPTH));
    pop          = OUT_VALID && OUT_READY;
    push         = byte_done_q && (!full || pop);
    drop         = byte_done_q && full && !pop;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d   = overflow_q | drop;
    byte_count_d = push ? byte_count_q + 16'd1 : byte_count_q;
    last_d       = pop ? mem_q[rd_ptr_q] : last_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      timer_q      <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_done_q  <= 1'b0;
      line_end_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      sim_end_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= 16'd0;
      last_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      sync1_q      <= RXD;
      rx_s_q       <= sync1_q;
      rx_prev_q    <= rx_s_q;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_done_q  <= byte_done_d;
      line_end_q   <= line_end_d;
      frame_err_q  <= frame_err_d;
      sim_end_q    <= sim_end_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      last_q       <= last_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign OUT_VALID     = (count_q != '0);
  assign OUT_DATA      = OUT_VALID ? mem_q[rd_ptr_q] : last_q;
  assign LINE_END      = line_end_q;
  assign FRAME_ERR     = frame_err_q;
  assign OVERFLOW      = overflow_q;
  assign SIMULATIONEND = sim_end_q;
  assign BYTE_COUNT    = byte_count_q;

`ifdef UART_STREAM_CAPTURE_DISPLAY_EN
  logic line_start_q;
  int   eot_cnt_q;

  always @(posedge CLK) begin
    if (RESET) begin
      line_start_q <= 1'b1;
      eot_cnt_q    <= 0;
    end else begin
      if (byte_done_q) begin
        if (line_start_q) $write("[UART] ");
        $write("%c", shift_q);
        line_start_q <= (shift_q == EOL_CHAR);
        if (shift_q == EOT_CHAR) begin
          $display("\nTest Ended");
          eot_cnt_q <= 10;
        end
      end
      if (frame_err_q) $display("[UART] warning: frame error at %0t", $time);
      if (drop) $display("[UART] warning: FIFO overflow, byte dropped at %0t", $time);
      if (eot_cnt_q > 0) begin
        if (eot_cnt_q == 1) $finish;
        eot_cnt_q <= eot_cnt_q - 1;
      end
    end
  end
`endif

endmodule
